lc3_fetch_queue: RTL and testbench
==================================

LC3_FETCH_QUEUE -- requirements
Module: lc3_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h3000: fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction queue entries (legal 2..4).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc  output  16  instruction-memory read address (fetch PC register).
REQ-006 SHALL have port instrmem_rd  output  1  instruction-memory read strobe, sampled by memory on the same edge as pc.
REQ-007 SHALL have port Instr_dout  input  16  instruction word, valid in the cycle after an accepted read when complete_instr=1.
REQ-008 SHALL have port complete_instr  input  1  memory completion; 0 stretches the outstanding read.
REQ-009 SHALL have port br_taken  input  1  redirect request from execute/writeback.
REQ-010 SHALL have port br_target  input  16  redirect address.
REQ-011 SHALL have port decode_ready  input  1  decode stage accepts the head entry this cycle.
REQ-012 SHALL have port instr_valid  output  1  queue head valid.
REQ-013 SHALL have port instr_out  output  16  queue head instruction.
REQ-014 SHALL have port npc_out  output  16  queue head fetch address + 1.
REQ-015 SHALL have port queue_count  output  3  entries currently held (0..DEPTH).

Function
REQ-016 SHALL implement FSM states IDLE (no read outstanding), WAIT (one read outstanding), DROP (outstanding read to be discarded).
REQ-017 SHALL allow at most one outstanding read.
REQ-018 SHALL define occ = queue_count + (state==WAIT) - pop, pop = instr_valid & decode_ready.
REQ-019 SHALL drive instrmem_rd=1 combinationally iff !reset, !br_taken, state!=DROP, not (WAIT & !complete_instr), and occ < DEPTH.
REQ-020 SHALL, on each edge with instrmem_rd=1, latch req_pc<=pc, set pc<=pc+1 (mod 2^16, 16'hFFFF -> 16'h0000), and enter WAIT.
REQ-021 SHALL, in WAIT with complete_instr=1 and !br_taken, push {Instr_dout, req_pc+1} to the queue tail; next state WAIT if a new read issued, else IDLE.
REQ-022 SHALL hold pc, req_pc and state in WAIT while complete_instr=0.
REQ-023 SHALL sustain one instruction per cycle back-to-back when complete_instr=1 and decode_ready=1.
REQ-024 SHALL present queue head combinationally on instr_out/npc_out; instr_out=npc_out=16'h0 when empty.
REQ-025 SHALL pop the head on pop; simultaneous push and pop leaves queue_count unchanged.
REQ-026 SHALL never overflow: REQ-019 guarantees a push always has room; never underflow: pop requires instr_valid.
REQ-027 SHALL, on br_taken, flush the queue (queue_count<=0), set pc<=br_target, suppress instrmem_rd that cycle, and ignore decode_ready.
REQ-028 SHALL, on br_taken: IDLE->IDLE; WAIT with complete_instr=1 -> IDLE, returned word discarded; WAIT with complete_instr=0 -> DROP.
REQ-029 SHALL, in DROP, discard Instr_dout and go to IDLE on complete_instr=1; a further br_taken in DROP updates pc only.
REQ-030 SHALL give first-instruction latency of 2 cycles from reset deassertion to instr_valid=1 (memory latency 1).

Reset
REQ-031 SHALL, while reset=1, set pc=RESET_PC, state=IDLE, queue_count=0, instr_valid=0, instr_out=16'h0, npc_out=16'h0, instrmem_rd=0.
REQ-032 SHALL, on reset asserted mid-read (WAIT/DROP), abandon the read; data returned after reset is ignored.
REQ-033 SHALL give reset priority over br_taken and all other inputs.

Verification
REQ-034 SHALL verify streaming: reset released, complete_instr=1, decode_ready=1, mem[3000..3003]=1111,2222,3333,4444 -> instr_out 1111,2222,3333,4444 on consecutive cycles, npc_out 3001..3004.
REQ-035 SHALL verify backpressure: decode_ready=0 -> queue_count saturates at 2, instrmem_rd=0, pc=3002; decode_ready=1 -> order preserved, no loss or duplicate.
REQ-036 SHALL verify redirect: br_taken=1, br_target=16'h3050 during WAIT with complete_instr=1 -> queue_count=0 next cycle, first valid instruction afterwards has npc_out=3051.
REQ-037 SHALL verify stalled redirect: complete_instr=0 for 3 cycles, br_taken pulsed in cycle 1 -> DROP, stale word discarded, next read at pc=br_target.
REQ-038 SHALL verify wrap: RESET_PC=16'hFFFF -> first npc_out=16'h0000, second fetch address 16'h0000.
REQ-039 SHALL verify reset mid-operation: reset asserted with queue_count=2 and read outstanding -> all outputs at reset values next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/lc3_fetch_queue.sv
// LC-3 instruction fetch unit: single-outstanding memory read feeding a small
// in-order queue toward decode, with branch redirect and stale-read discard.
//   state | meaning
//   IDLE  | no read outstanding
//   WAIT  | one read outstanding, its word is kept on completion
//   DROP  | one read outstanding, its word is thrown away on completion
module lc3_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] pc,
    output logic        instrmem_rd,
    input  logic [15:0] Instr_dout,
    input  logic        complete_instr,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] npc_out,
    output logic [2:0]  queue_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc_q;
    logic [15:0] req_pc;
    logic [2:0]  count;
    logic [1:0]  head;
    logic [1:0]  tail;
    logic        push;
    logic        pop;
    logic [3:0]  occ;

    // Storage is sized for the largest legal depth so 2-bit pointers index it cleanly.
    logic [15:0] instr_mem [4];
    logic [15:0] npc_mem   [4];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign instr_valid = !reset && (count != 3'd0);
    assign queue_count = reset ? 3'd0 : count;
    assign pc          = reset ? RESET_PC : pc_q;
    assign instr_out   = instr_valid ? instr_mem[head] : 16'h0;
    assign npc_out     = instr_valid ? npc_mem[head]   : 16'h0;

    assign pop  = instr_valid && decode_ready && !br_taken;
    assign push = !reset && !br_taken && (state == WAIT) && complete_instr;

    // Occupancy counts the in-flight read so a new read always has a slot to land in.
    assign occ = {1'b0, count} + {3'b0, state == WAIT} - {3'b0, pop};

    assign instrmem_rd = !reset && !br_taken && (state != DROP)
                         && !((state == WAIT) && !complete_instr)
                         && (occ < 4'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            req_pc <= RESET_PC;
            state  <= IDLE;
            count  <= 3'd0;
            head   <= 2'd0;
            tail   <= 2'd0;
        end else if (br_taken) begin
            pc_q  <= br_target;
            count <= 3'd0;
            head  <= 2'd0;
            tail  <= 2'd0;
            state <= ((state != IDLE) && !complete_instr) ? DROP : IDLE;
        end else begin
            if (instrmem_rd) begin
                req_pc <= pc_q;
                pc_q   <= pc_q + 16'd1;
                state  <= WAIT;
            end else if ((state != IDLE) && complete_instr) begin
                state <= IDLE;
            end
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            count <= count + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[tail] <= Instr_dout;
            npc_mem[tail]   <= req_pc + 16'd1;
        end
    end

endmodule

// File: tb/tb_lc3_fetch_queue.sv
// Bench for lc3_fetch_queue: expected head words are queued by the stimulus and
// checked by a monitor on every accepted pop; a second instance covers PC wrap.
module tb_lc3_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        complete_instr;
    logic        br_taken;
    logic [15:0] br_target;
    logic        decode_ready;

    logic [15:0] pc, instr_dout, instr_out, npc_out;
    logic        instrmem_rd, instr_valid;
    logic [2:0]  queue_count;

    logic [15:0] pc_w, instr_dout_w, instr_out_w, npc_out_w;
    logic        instrmem_rd_w, instr_valid_w;
    logic [2:0]  queue_count_w;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    lc3_fetch_queue #(.RESET_PC(16'h3000), .DEPTH(2)) dut (
        .clock(clk), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
        .Instr_dout(instr_dout), .complete_instr(complete_instr),
        .br_taken(br_taken), .br_target(br_target), .decode_ready(decode_ready),
        .instr_valid(instr_valid), .instr_out(instr_out), .npc_out(npc_out),
        .queue_count(queue_count)
    );

    lc3_fetch_queue #(.RESET_PC(16'hFFFF), .DEPTH(3)) dut_w (
        .clock(clk), .reset(reset), .pc(pc_w), .instrmem_rd(instrmem_rd_w),
        .Instr_dout(instr_dout_w), .complete_instr(complete_instr),
        .br_taken(br_taken), .br_target(br_target), .decode_ready(decode_ready),
        .instr_valid(instr_valid_w), .instr_out(instr_out_w), .npc_out(npc_out_w),
        .queue_count(queue_count_w)
    );

    function automatic logic [15:0] memval(input logic [15:0] a);
        case (a)
            16'h3000: return 16'h1111;
            16'h3001: return 16'h2222;
            16'h3002: return 16'h3333;
            16'h3003: return 16'h4444;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    // One-cycle memory: address taken on the read edge, word valid next cycle.
    always @(posedge clk) begin
        if (instrmem_rd)   instr_dout   <= memval(pc);
        if (instrmem_rd_w) instr_dout_w <= memval(pc_w);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && instr_valid && decode_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {instr_out, npc_out}, 32'hxxxx_xxxx);
            end else begin
                chk("head_word", {instr_out, npc_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; br_taken = 1'b0; br_target = 16'h0;
        complete_instr = 1'b1; decode_ready = 1'b0;
        step();
        step();
        chk("rst_pc",      32'(pc), 32'h3000);
        chk("rst_rd",      32'(instrmem_rd), 32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_count",   32'(queue_count), 32'd0);
        chk("rst_instr",   32'(instr_out), 32'd0);
        chk("rst_npc",     32'(npc_out), 32'd0);
        chk("rst_pc_w",    32'(pc_w), 32'hFFFF);
        chk("rst_valid_w", 32'(instr_valid_w), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    task automatic drained(input string name);
        step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // streaming plus wrap on the second instance
        do_reset();
        decode_ready = 1'b1;
        exp_q.push_back({16'h1111, 16'h3001});
        exp_q.push_back({16'h2222, 16'h3002});
        exp_q.push_back({16'h3333, 16'h3003});
        exp_q.push_back({16'h4444, 16'h3004});
        #1;
        chk("lat_c0_valid", 32'(instr_valid), 32'd0);
        chk("wrap_pc0",     32'(pc_w), 32'hFFFF);
        chk("wrap_rd0",     32'(instrmem_rd_w), 32'd1);
        step();
        chk("lat_c1_valid", 32'(instr_valid), 32'd0);
        chk("wrap_pc1",     32'(pc_w), 32'h0000);
        chk("wrap_rd1",     32'(instrmem_rd_w), 32'd1);
        step();
        chk("lat_c2_valid", 32'(instr_valid), 32'd1);
        chk("wrap_npc",     32'(npc_out_w), 32'h0000);
        chk("wrap_instr",   32'(instr_out_w), 32'h5A5A);
        repeat (4) step();
        decode_ready = 1'b0;
        drained("stream_drained");

        // backpressure
        do_reset();
        repeat (4) step();
        chk("bp_count", 32'(queue_count), 32'd2);
        chk("bp_rd",    32'(instrmem_rd), 32'd0);
        chk("bp_pc",    32'(pc), 32'h3002);
        exp_q.push_back({16'h1111, 16'h3001});
        exp_q.push_back({16'h2222, 16'h3002});
        exp_q.push_back({16'h3333, 16'h3003});
        exp_q.push_back({16'h4444, 16'h3004});
        step();
        decode_ready = 1'b1;
        repeat (4) step();
        decode_ready = 1'b0;
        drained("bp_drained");

        // redirect while the read completes
        do_reset();
        step();
        br_taken = 1'b1; br_target = 16'h3050;
        #1;
        chk("br_rd_suppressed", 32'(instrmem_rd), 32'd0);
        step();
        br_taken = 1'b0;
        #1;
        chk("br_count", 32'(queue_count), 32'd0);
        chk("br_pc",    32'(pc), 32'h3050);
        chk("br_rd",    32'(instrmem_rd), 32'd1);
        decode_ready = 1'b1;
        exp_q.push_back({16'h95F5, 16'h3051});
        step();
        step();
        step();
        decode_ready = 1'b0;
        drained("br_drained");

        // redirect during a stalled read
        do_reset();
        step();
        complete_instr = 1'b0; br_taken = 1'b1; br_target = 16'h3080;
        #1;
        chk("drop_rd_c1", 32'(instrmem_rd), 32'd0);
        step();
        br_taken = 1'b0;
        #1;
        chk("drop_rd_c2", 32'(instrmem_rd), 32'd0);
        chk("drop_pc_c2", 32'(pc), 32'h3080);
        step();
        chk("drop_rd_c3", 32'(instrmem_rd), 32'd0);
        step();
        complete_instr = 1'b1;
        #1;
        chk("drop_rd_c4", 32'(instrmem_rd), 32'd0);
        step();
        chk("drop_rd_c5",    32'(instrmem_rd), 32'd1);
        chk("drop_pc_c5",    32'(pc), 32'h3080);
        chk("drop_count_c5", 32'(queue_count), 32'd0);
        decode_ready = 1'b1;
        exp_q.push_back({16'h9525, 16'h3081});
        step();
        step();
        step();
        decode_ready = 1'b0;
        drained("drop_drained");

        // reset with a full queue and a read outstanding
        do_reset();
        repeat (3) step();
        chk("mid_count",   32'(queue_count), 32'd2);
        chk("mid_count_w", 32'(queue_count_w), 32'd2);
        chk("mid_rd_w",    32'(instrmem_rd_w), 32'd0);
        complete_instr = 1'b0;
        reset = 1'b1;
        step();
        complete_instr = 1'b1;
        #1;
        chk("mid_valid",   32'(instr_valid), 32'd0);
        chk("mid_cnt0",    32'(queue_count), 32'd0);
        chk("mid_instr",   32'(instr_out), 32'd0);
        chk("mid_npc",     32'(npc_out), 32'd0);
        chk("mid_rd",      32'(instrmem_rd), 32'd0);
        chk("mid_pc",      32'(pc), 32'h3000);
        chk("mid_valid_w", 32'(instr_valid_w), 32'd0);
        chk("mid_cnt0_w",  32'(queue_count_w), 32'd0);
        chk("mid_pc_w",    32'(pc_w), 32'hFFFF);
        reset = 1'b0;
        decode_ready = 1'b1;
        #1;
        chk("restart_rd",   32'(instrmem_rd), 32'd1);
        chk("restart_pc",   32'(pc), 32'h3000);
        chk("restart_rd_w", 32'(instrmem_rd_w), 32'd1);
        exp_q.push_back({16'h1111, 16'h3001});
        step();
        step();
        step();
        decode_ready = 1'b0;
        drained("restart_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
